// File: rtl/wshb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single SDRAM slave.
// The owner holds the bus for its whole cyc period; ties go to the master not served last.
module wshb_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_ms,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic              m0_ack,
  output logic              m0_err,
  output logic              m0_rty,
  output logic [DATA_W-1:0] m0_dat_sm,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_ms,
  input  logic [SEL_W-1:0]  m1_sel,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              m1_rty,
  output logic [DATA_W-1:0] m1_dat_sm,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_ms,
  output logic [SEL_W-1:0]  s_sel,
  input  logic              s_ack,
  input  logic              s_err,
  input  logic              s_rty,
  input  logic [DATA_W-1:0] s_dat_sm,
  output logic [1:0]        gnt
);

  // One-hot encoding lets gnt come straight off the state flops.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   last;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT0) last <= 1'b0;
      else if (state_nxt == GNT1) last <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc)      state_nxt = GNT0;
        else if (m1_cyc)      state_nxt = GNT1;
      end
      GNT0: if (!m0_cyc) state_nxt = m1_cyc ? GNT1 : IDLE;
      GNT1: if (!m1_cyc) state_nxt = m0_cyc ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt       = state;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // Responses are gated with the owner's cyc so late acks after a drop are swallowed.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rty   = 1'b0;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        m0_ack   = s_ack & m0_cyc;
        m0_err   = s_err & m0_cyc;
        m0_rty   = s_rty & m0_cyc;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        m1_ack   = s_ack & m1_cyc;
        m1_err   = s_err & m1_cyc;
        m1_rty   = s_rty & m1_cyc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Self-checking bench for wshb_rr_arbiter: vector table through a scoreboard queue,
// then hand sequences for tie-break, fairness, burst lock and mid-burst reset.
module tb_wshb_rr_arbiter;

  logic        sys_clk, sys_rst;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err, m0_rty;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err, m1_rty;
  logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0]  m1_sel;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;
  logic        auto_ack, s_ack_man;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  wshb_rr_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
    .gnt(gnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Zero-wait slave when auto_ack is set, otherwise ack driven by hand.
  assign s_ack = auto_ack ? (s_cyc & s_stb) : s_ack_man;

  typedef struct {
    logic        m0c, m0s, m1c, m1s, ack;
    logic [1:0]  gnt;
    logic        scyc;
    logic [31:0] sadr;
    logic        a0, a1;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];
  int   order_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clr_in();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    s_ack_man = 0; s_err = 0; s_rty = 0; auto_ack = 0;
  endtask

  // Leaves time at posedge+1 with the arbiter in IDLE and last=1.
  task automatic do_reset();
    clr_in();
    sys_rst = 1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst = 0;
  endtask

  initial begin
    vec_t e;
    int   rem0, rem1, n0, n1, exp_m;
    logic got0, got1;

    m0_we = 0; m0_adr = 32'h100; m0_dat_ms = 32'h1111_0000; m0_sel = 4'hF;
    m1_we = 1; m1_adr = 32'h200; m1_dat_ms = 32'h2222_0000; m1_sel = 4'h3;
    s_dat_sm = 32'hCAFE_BABE;
    clr_in();

    // Reset holds everything quiet even with every request and ack asserted.
    sys_rst = 1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack_man = 1;
    #3;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    #10;
    chk("rst_gnt_after_edge", gnt, 2'b00);
    chk("rst_s_stb", s_stb, 0);
    do_reset();

    //           m0c m0s m1c m1s ack  gnt  scyc sadr    a0 a1
    vecs[0]  = '{0, 0, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 2'b00, 0, 32'h000, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0};
    vecs[3]  = '{1, 1, 0, 0, 1, 2'b01, 1, 32'h100, 1, 0};
    vecs[4]  = '{0, 0, 1, 1, 1, 2'b01, 0, 32'h100, 0, 0};
    vecs[5]  = '{1, 1, 1, 1, 1, 2'b10, 1, 32'h200, 0, 1};
    vecs[6]  = '{1, 1, 1, 1, 0, 2'b10, 1, 32'h200, 0, 0};
    vecs[7]  = '{1, 1, 0, 0, 0, 2'b10, 0, 32'h200, 0, 0};
    vecs[8]  = '{1, 1, 0, 0, 1, 2'b01, 1, 32'h100, 1, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 2'b01, 0, 32'h100, 0, 0};
    vecs[10] = '{1, 1, 1, 1, 0, 2'b00, 0, 32'h000, 0, 0};
    vecs[11] = '{1, 1, 1, 1, 1, 2'b10, 1, 32'h200, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 2'b10, 0, 32'h200, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0};

    for (int i = 0; i < 14; i++) begin
      m0_cyc = vecs[i].m0c; m0_stb = vecs[i].m0s;
      m1_cyc = vecs[i].m1c; m1_stb = vecs[i].m1s;
      s_ack_man = vecs[i].ack;
      sb_q.push_back(vecs[i]);
      #2;
      e = sb_q.pop_front();
      chk($sformatf("v%0d_gnt", i), gnt, e.gnt);
      chk($sformatf("v%0d_s_cyc", i), s_cyc, e.scyc);
      chk($sformatf("v%0d_s_adr", i), s_adr, e.sadr);
      chk($sformatf("v%0d_acks", i), {m0_ack, m1_ack}, {e.a0, e.a1});
      chk($sformatf("v%0d_s_we", i), s_we, e.gnt[1]);
      chk($sformatf("v%0d_s_sel", i), s_sel, e.gnt[0] ? 4'hF : (e.gnt[1] ? 4'h3 : 4'h0));
      chk($sformatf("v%0d_s_dat", i), s_dat_ms,
          e.gnt[0] ? 32'h1111_0000 : (e.gnt[1] ? 32'h2222_0000 : 32'h0));
      @(posedge sys_clk);
      #1;
    end
    chk("m0_dat_sm", m0_dat_sm, 32'hCAFE_BABE);
    chk("m1_dat_sm", m1_dat_sm, 32'hCAFE_BABE);

    // Tie right after reset: m0 first, then m1 with no idle gap.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(posedge sys_clk); #1;
    chk("tie_first_gnt", gnt, 2'b01);
    s_err = 1; #1;
    chk("err_to_m0", {m0_err, m1_err}, 2'b10);
    s_err = 0;
    m0_cyc = 0; m0_stb = 0;
    @(posedge sys_clk); #1;
    chk("tie_second_gnt", gnt, 2'b10);
    s_rty = 1; #1;
    chk("rty_to_m1", {m0_rty, m1_rty}, 2'b01);
    s_rty = 0;

    // Asynchronous reset in the middle of m1's cycle.
    s_ack_man = 1; #1;
    sys_rst = 1; #1;
    chk("midrst_s_cyc", s_cyc, 0);
    chk("midrst_gnt", gnt, 2'b00);
    chk("midrst_m1_ack", m1_ack, 0);
    s_ack_man = 0;
    m0_cyc = 1; m0_stb = 1;
    @(posedge sys_clk); #1 sys_rst = 0;
    @(posedge sys_clk); #1;
    chk("post_rst_gnt", gnt, 2'b01);

    // Fairness: 8 single transfers per master, back to back.
    do_reset();
    auto_ack = 1;
    for (int k = 0; k < 8; k++) begin
      order_q.push_back(0);
      order_q.push_back(1);
    end
    rem0 = 8; rem1 = 8; n0 = 0; n1 = 0; got0 = 0; got1 = 0;
    for (int c = 0; c < 300 && (rem0 > 0 || rem1 > 0); c++) begin
      m0_cyc = (rem0 > 0) && !got0; m0_stb = m0_cyc;
      m1_cyc = (rem1 > 0) && !got1; m1_stb = m1_cyc;
      #3;
      got0 = m0_ack; got1 = m1_ack;
      if (got0 || got1) begin
        exp_m = (order_q.size() > 0) ? order_q.pop_front() : -1;
        chk("fair_order", got1 ? 1 : 0, exp_m);
      end
      if (got0) begin rem0--; n0++; end
      if (got1) begin rem1--; n1++; end
      @(posedge sys_clk); #1;
    end
    chk("fair_done", (rem0 == 0 && rem1 == 0), 1);
    chk("fair_m0_acks", n0, 8);
    chk("fair_m1_acks", n1, 8);

    // Burst lock: m0 holds cyc for 16 beats while m1 keeps requesting.
    do_reset();
    auto_ack = 1;
    n0 = 0; n1 = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int c = 0; c < 100 && n0 < 16; c++) begin
      #3;
      if (m0_ack) n0++;
      if (m1_ack || gnt == 2'b10) n1++;
      @(posedge sys_clk); #1;
    end
    m0_cyc = 0; m0_stb = 0; #1;
    chk("burst_m0_acks", n0, 16);
    chk("burst_m1_intrusions", n1, 0);
    chk("burst_drop_s_cyc", s_cyc, 0);
    @(posedge sys_clk); #1;
    chk("burst_handover_gnt", gnt, 2'b10);
    clr_in();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
